// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, byte-programmable instruction memory,
// and a RUN/FAULT state machine that parks the PC on an invalid fetch.
module instruction_fetch #(
    parameter int          MEM_BYTES = 256,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSN  = 32'h00000013
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         redirect_valid,
    input  logic [63:0]                  redirect_pc,
    input  logic                         prog_we,
    input  logic [$clog2(MEM_BYTES)-1:0] prog_addr,
    input  logic [7:0]                   prog_data,
    output logic [63:0]                  pc_out,
    output logic [31:0]                  instruction,
    output logic                         flush,
    output logic                         fault,
    output logic [31:0]                  fetch_count
);

    localparam int ADDR_W = $clog2(MEM_BYTES);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    logic [7:0]        mem [MEM_BYTES];
    logic [63:0]       pc;
    state_t            state;
    logic [31:0]       count;
    logic [63:0]       pc_plus3;
    logic              fetch_valid;
    logic              stall_eff;
    logic [ADDR_W-1:0] base;

    // An undriven stall from the hazard unit must not freeze the pipeline.
    assign stall_eff = (stall === 1'b1);

    // The last byte of the word must lie inside memory; the compare is full width
    // so a huge redirect target can never alias into the array.
    assign pc_plus3    = pc + 64'd3;
    assign fetch_valid = (pc[1:0] == 2'b00) && (pc_plus3 < 64'(MEM_BYTES));
    assign base        = pc[ADDR_W-1:0];

    always_comb begin
        // NOTE: default first so every path assigns instruction and no latch is inferred.
        instruction = NOP_INSN;
        if (state == RUN && fetch_valid) begin
            instruction = {mem[base + ADDR_W'(3)], mem[base + ADDR_W'(2)],
                           mem[base + ADDR_W'(1)], mem[base]};
        end
    end

    // Redirect beats stall; an invalid fetch without redirect faults even while stalled.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            pc    <= RESET_PC;
            state <= RUN;
            count <= '0;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= RUN;
        end else if (!fetch_valid) begin
            state <= FAULT;
        end else if (state == RUN && !stall_eff) begin
            pc    <= pc + 64'd4;
            count <= count + 32'd1;
        end
    end

    // NOTE: the memory array has no reset; its contents survive reset by design.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign pc_out      = pc;
    assign fault       = (state == FAULT);
    assign fetch_count = count;
    assign flush       = redirect_valid & ~reset;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written corner
// sequences, then randomized traffic compared against a behavioural model.
module tb_instruction_fetch;

    localparam int          MEM = 256;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, prog_we;
    logic [63:0] redirect_pc;
    logic [7:0]  prog_addr, prog_data;
    logic [63:0] pc_out;
    logic [31:0] instruction, fetch_count;
    logic        flush, fault;

    always #5 clk = ~clk;

    instruction_fetch #(
        .MEM_BYTES(MEM),
        .RESET_PC (64'h0),
        .NOP_INSN (NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .pc_out        (pc_out),
        .instruction   (instruction),
        .flush         (flush),
        .fault         (fault),
        .fetch_count   (fetch_count)
    );

    int checks   = 0;
    int failures = 0;
    bit checking = 1'b0;

    // Behavioural model: byte array, PC, sticky fault flag, issue counter.
    logic [7:0]  m_mem [MEM];
    logic [63:0] m_pc;
    bit          m_fault;
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_valid();
        return (m_pc % 64'd4 == 64'd0) && (m_pc <= 64'(MEM - 4));
    endfunction

    function automatic logic [31:0] m_insn();
        int a;
        if (m_fault || !m_valid()) return NOP;
        a = int'(m_pc);
        return {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
    endfunction

    task automatic m_edge();
        bit v;
        v = m_valid();
        if (reset) begin
            m_pc    = 64'h0;
            m_fault = 1'b0;
            m_cnt   = 32'd0;
        end else if (redirect_valid) begin
            m_pc    = redirect_pc;
            m_fault = 1'b0;
        end else if (!v) begin
            m_fault = 1'b1;
        end else if (!stall && !m_fault) begin
            m_pc  = m_pc + 64'd4;
            m_cnt = m_cnt + 32'd1;
        end
        if (prog_we) m_mem[prog_addr] = prog_data;
    endtask

    // Apply inputs, compare all outputs before the edge, advance one clock.
    task automatic cycle(input bit r, input bit s, input bit rv, input logic [63:0] rp,
                         input bit we, input logic [7:0] pa, input logic [7:0] pd);
        reset = r; stall = s; redirect_valid = rv; redirect_pc = rp;
        prog_we = we; prog_addr = pa; prog_data = pd;
        #1;
        if (checking) begin
            check("flush", {63'd0, flush}, {63'd0, rv & ~r});
            check("instruction", {32'd0, instruction}, {32'd0, m_insn()});
            check("pc_out", pc_out, m_pc);
            check("fault", {63'd0, fault}, {63'd0, m_fault});
            check("fetch_count", {32'd0, fetch_count}, {32'd0, m_cnt});
        end
        m_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] init_byte(input int i);
        logic [31:0] w0, w1;
        w0 = 32'h00500093;
        w1 = 32'h00108113;
        if (i < 4) return w0[8*i +: 8];
        if (i < 8) return w1[8*(i-4) +: 8];
        return 8'((i * 7 + 3) & 255);
    endfunction

    typedef struct {
        bit          stall;
        bit          redir;
        logic [63:0] rpc;
        logic [63:0] exp_pc;
        bit          exp_fault;
        logic [31:0] exp_cnt;
        bit          chk_insn;
        logic [31:0] exp_insn;
    } vec_t;

    vec_t vecs [17];

    initial begin
        vecs[0]  = '{0, 0, 64'h0,   64'h4,   0, 32'd1, 1, 32'h00108113};
        vecs[1]  = '{0, 0, 64'h0,   64'h8,   0, 32'd2, 0, 32'h0};
        vecs[2]  = '{1, 0, 64'h0,   64'h8,   0, 32'd2, 0, 32'h0};
        vecs[3]  = '{1, 0, 64'h0,   64'h8,   0, 32'd2, 0, 32'h0};
        vecs[4]  = '{1, 0, 64'h0,   64'h8,   0, 32'd2, 0, 32'h0};
        vecs[5]  = '{0, 0, 64'h0,   64'hC,   0, 32'd3, 0, 32'h0};
        vecs[6]  = '{0, 0, 64'h0,   64'h10,  0, 32'd4, 0, 32'h0};
        vecs[7]  = '{1, 1, 64'h40,  64'h40,  0, 32'd4, 0, 32'h0};
        vecs[8]  = '{0, 1, 64'h102, 64'h102, 0, 32'd4, 1, NOP};
        vecs[9]  = '{0, 0, 64'h0,   64'h102, 1, 32'd4, 1, NOP};
        vecs[10] = '{1, 0, 64'h0,   64'h102, 1, 32'd4, 0, 32'h0};
        vecs[11] = '{0, 1, 64'h0,   64'h0,   0, 32'd4, 1, 32'h00500093};
        vecs[12] = '{0, 0, 64'h0,   64'h4,   0, 32'd5, 0, 32'h0};
        vecs[13] = '{0, 1, 64'hFC,  64'hFC,  0, 32'd5, 0, 32'h0};
        vecs[14] = '{0, 0, 64'h0,   64'h100, 0, 32'd6, 1, NOP};
        vecs[15] = '{0, 0, 64'h0,   64'h100, 1, 32'd6, 0, 32'h0};
        vecs[16] = '{0, 0, 64'h0,   64'h100, 1, 32'd6, 0, 32'h0};

        // Program the whole memory while held in reset.
        for (int i = 0; i < MEM; i++) cycle(1, 0, 0, 64'h0, 1, 8'(i), init_byte(i));
        checking = 1'b1;

        // Reset with redirect and stall asserted: both ignored, flush forced low.
        cycle(1, 1, 1, 64'h80, 0, 8'h0, 8'h0);
        check("reset pc", pc_out, 64'h0);
        check("reset count", {32'd0, fetch_count}, 64'd0);

        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; #1;
        check("cycle0 insn", {32'd0, instruction}, 64'h00500093);

        foreach (vecs[i]) begin
            cycle(0, vecs[i].stall, vecs[i].redir, vecs[i].rpc, 0, 8'h0, 8'h0);
            check($sformatf("vec%0d pc", i), pc_out, vecs[i].exp_pc);
            check($sformatf("vec%0d fault", i), {63'd0, fault}, {63'd0, vecs[i].exp_fault});
            check($sformatf("vec%0d count", i), {32'd0, fetch_count}, {32'd0, vecs[i].exp_cnt});
            if (vecs[i].chk_insn)
                check($sformatf("vec%0d insn", i), {32'd0, instruction}, {32'd0, vecs[i].exp_insn});
        end

        // Reset from FAULT with stall and redirect asserted; memory must survive.
        cycle(1, 1, 1, 64'h80, 0, 8'h0, 8'h0);
        check("fault reset pc", pc_out, 64'h0);
        check("fault reset fault", {63'd0, fault}, 64'd0);
        check("fault reset count", {32'd0, fetch_count}, 64'd0);
        reset = 1'b0; stall = 1'b1; redirect_valid = 1'b0; #1;
        check("mem intact", {32'd0, instruction}, 64'h00500093);

        // Same-cycle write to the byte being fetched: old value until the edge.
        reset = 1'b0; stall = 1'b1; prog_we = 1'b1; prog_addr = 8'h0; prog_data = 8'hAA; #1;
        check("write old value", {32'd0, instruction}, 64'h00500093);
        cycle(0, 1, 0, 64'h0, 1, 8'h0, 8'hAA);
        check("write new value", {32'd0, instruction}, 64'h005000AA);
        cycle(0, 1, 0, 64'h0, 1, 8'h0, 8'h93);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit          r, s, rv, we;
            logic [63:0] rp;
            int          kind;
            r    = ($urandom_range(0, 49) == 0);
            s    = ($urandom_range(0, 3) == 0);
            rv   = ($urandom_range(0, 7) == 0);
            we   = ($urandom_range(0, 3) == 0);
            kind = $urandom_range(0, 9);
            if (kind < 6)       rp = 64'($urandom_range(0, 70) * 4);
            else if (kind < 8)  rp = 64'($urandom_range(0, 300));
            else if (kind == 8) rp = 64'hFFFF_FFFF_FFFF_FFFC;
            else                rp = {$urandom, $urandom};
            cycle(r, s, rv, rp, we, 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter MEM_BYTES, default 256: instruction memory size in bytes, a power of two.
REQ-002 Parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-003 Parameter NOP_INSN, default 32'h00000013: instruction word presented whenever no valid fetch exists.
REQ-004 Ports, name direction width meaning:
 clk  input  1  rising-edge clock
 reset  input  1  synchronous, active-high reset
 stall  input  1  hold PC; from hazard unit
 redirect_valid  input  1  taken branch/jump this cycle
 redirect_pc  input  64  branch/jump target
 prog_we  input  1  instruction-memory byte write enable
 prog_addr  input  8  byte address for write, log2(MEM_BYTES) bits
 prog_data  input  8  byte written
 pc_out  output  64  PC of the presented instruction, feeds IF/ID
 instruction  output  32  fetched instruction word, feeds IF/ID
 flush  output  1  squash request for the IF/ID contents
 fault  output  1  fetch fault state indicator
 fetch_count  output  32  count of instructions issued downstream
REQ-005 Reset is reset, synchronous, active-high; clock is clk.

Function
REQ-006 The block SHALL hold a 64-bit PC register; pc_out SHALL equal the PC register directly.
REQ-007 Memory SHALL be a MEM_BYTES byte array, read combinationally, little-endian: instruction = {mem[PC+3], mem[PC+2], mem[PC+1], mem[PC]}.
REQ-008 A fetch is valid when PC[1:0]==0 and PC+3 < MEM_BYTES (unsigned, 64-bit compare); otherwise instruction SHALL be NOP_INSN.
REQ-009 In state FAULT, instruction SHALL be NOP_INSN regardless of PC.
REQ-010 FSM states RUN and FAULT; reset state RUN.
REQ-011 RUN->FAULT at a clock edge where the fetch is invalid and redirect_valid=0 (stall does not block the transition).
REQ-012 FAULT->RUN only at an edge with redirect_valid=1; FAULT is otherwise sticky.
REQ-013 fault SHALL be 1 exactly while state is FAULT.
REQ-014 PC update priority at each non-reset edge: redirect_valid=1 -> PC<=redirect_pc; else stall=1 -> hold; else FAULT or invalid fetch -> hold; else PC<=PC+4.
REQ-015 Redirect SHALL override stall in the same cycle.
REQ-016 stall equal to X SHALL be treated as 0.
REQ-017 PC+4 SHALL wrap modulo 2^64.
REQ-018 flush SHALL equal redirect_valid combinationally, forced to 0 while reset=1.
REQ-019 fetch_count SHALL increment by 1 at an edge where state=RUN, the fetch is valid, stall=0 and redirect_valid=0; it wraps from 32'hFFFFFFFF to 0.
REQ-020 When prog_we=1, mem[prog_addr] SHALL be written with prog_data at the rising edge, independent of stall, state and reset.
REQ-021 A same-cycle write to a byte being read SHALL show the old value until after the edge.
REQ-022 Redirect to an invalid address SHALL enter RUN with the new PC, then move to FAULT at the next edge per REQ-011.

Reset
REQ-023 At an edge with reset=1: PC<=RESET_PC, state<=RUN, fetch_count<=0; redirect and stall are ignored.
REQ-024 Memory contents SHALL NOT be altered by reset.
REQ-025 Reset asserted mid-stall or in FAULT SHALL yield the same state as a power-on reset after one edge.

Verification
REQ-026 Load words 0x00500093 at byte 0 and 0x00108113 at byte 4, then release reset -> cycle 0: pc_out=0, instruction=0x00500093; cycle 1: pc_out=4, instruction=0x00108113; fetch_count=1 after the first edge.
REQ-027 At PC=8, assert stall for 3 cycles -> pc_out stays 8, fetch_count is unchanged; on release, PC advances to 12.
REQ-028 At PC=16 with stall=1, assert redirect_valid=1 and redirect_pc=0x40 -> flush=1 that cycle; the next pc_out=0x40; fetch_count is unchanged.
REQ-029 Redirect to PC=0x102 (misaligned and out of range) -> the next cycle shows instruction=0x00000013 and fault=0; after one more edge fault=1 and the PC holds; redirect to 0 -> fault=0 and fetch resumes.
REQ-030 With PC=252 and MEM_BYTES=256 -> valid fetch; the next edge gives PC=256, then FAULT; reset -> pc_out=0, fault=0, fetch_count=0, and memory contents are intact.
